// File: rtl/pcf8591_stream_scheduler.sv
// pcf8591_stream_scheduler: streams DAC samples to a PCF8591 as one endless write transaction.
// A configuration change closes the transaction and reopens it with the new control byte.
module pcf8591_stream_scheduler #(
  parameter logic [7:0] DEV_ADDR   = 8'h90,
  parameter logic [7:0] CTRL_INIT  = 8'h40,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  smp_data,
  input  logic        smp_valid,
  output logic        smp_ready,
  input  logic [7:0]  cfg_ctrl,
  input  logic        cfg_req,
  output logic        cfg_busy,
  output logic        cfg_ack,
  input  logic        tx_ready,
  output logic [7:0]  tx_word,
  output logic        tx_stop,
  output logic [15:0] underrun_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {ADDR, CTRL, DATA} state_t;
  state_t state_q, state_d;
  logic [7:0] ctrl_q, ctrl_d, shadow_q, shadow_d, last_q, last_d;
  logic busy_q, busy_d, ack_q, ack_d, apply_q, apply_d;
  logic [15:0] under_q, under_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic empty, full, push, pop, pending;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push = smp_valid && !full;
  assign pop = tx_ready && state_q == DATA && !empty;
  // apply_q marks a transaction already carrying the new control byte, so busy is no longer pending
  assign pending = busy_q && !apply_q;
  assign smp_ready = !full;
  assign cfg_busy = busy_q;
  assign cfg_ack = ack_q;
  assign underrun_cnt = under_q;
  assign tx_word = state_q == ADDR ? DEV_ADDR : state_q == CTRL ? ctrl_q :
                   empty ? last_q : mem_q[rd_q[AW-1:0]];
  assign tx_stop = state_q == DATA && pending;
  always_comb begin
    state_d = state_q;
    ctrl_d = ctrl_q;
    shadow_d = (cfg_req && !busy_q) ? cfg_ctrl : shadow_q;
    busy_d = busy_q || cfg_req;
    ack_d = 1'b0;
    apply_d = apply_q;
    last_d = pop ? mem_q[rd_q[AW-1:0]] : last_q;
    under_d = under_q;
    wr_d = wr_q + {{AW{1'b0}}, push};
    rd_d = rd_q + {{AW{1'b0}}, pop};
    if (tx_ready) begin
      if (state_q == ADDR) state_d = CTRL;
      if (state_q == CTRL) begin
        state_d = DATA;
        ack_d = apply_q;
        busy_d = apply_q ? 1'b0 : busy_d;
        apply_d = 1'b0;
      end
      if (state_q == DATA) begin
        under_d = (empty && under_q != 16'hFFFF) ? under_q + 16'd1 : under_q;
        ctrl_d = pending ? shadow_q : ctrl_q;
        apply_d = pending;
        state_d = pending ? ADDR : DATA;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ADDR;
      ctrl_q <= CTRL_INIT;
      shadow_q <= 8'h00;
      last_q <= 8'h00;
      busy_q <= 1'b0;
      ack_q <= 1'b0;
      apply_q <= 1'b0;
      under_q <= 16'h0000;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      shadow_q <= shadow_d;
      last_q <= last_d;
      busy_q <= busy_d;
      ack_q <= ack_d;
      apply_q <= apply_d;
      under_q <= under_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= smp_data;
endmodule

// File: tb/tb_pcf8591_stream_scheduler.sv
// tb_pcf8591_stream_scheduler: directed stimulus with a byte scoreboard checked by a separate monitor.
module tb_pcf8591_stream_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] smp_data = 8'h00;
  logic smp_valid = 1'b0;
  logic smp_ready;
  logic [7:0] cfg_ctrl = 8'h00;
  logic cfg_req = 1'b0;
  logic cfg_busy, cfg_ack;
  logic tx_ready = 1'b0;
  logic [7:0] tx_word;
  logic tx_stop;
  logic [15:0] underrun_cnt;
  int passed = 0;
  int total = 0;
  int ack_seen = 0;
  logic [8:0] sb_q[$];
  logic [15:0] exp_under;

  pcf8591_stream_scheduler dut (
    .clk(clk), .reset(reset), .smp_data(smp_data), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .cfg_ctrl(cfg_ctrl), .cfg_req(cfg_req),
    .cfg_busy(cfg_busy), .cfg_ack(cfg_ack), .tx_ready(tx_ready),
    .tx_word(tx_word), .tx_stop(tx_stop), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input logic s);
    sb_q.push_back({s, w});
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cfg_ack) ack_seen++;
    if (!reset && tx_ready) begin
      total++;
      if (sb_q.size() == 0) begin
        $display("FAIL byte: got %h/%b with nothing expected", tx_word, tx_stop);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        if ({tx_stop, tx_word} === e) passed++;
        else $display("FAIL byte: got word %h stop %b expected word %h stop %b",
                      tx_word, tx_stop, e[7:0], e[8]);
      end
    end
  end

  initial begin
    #1 reset = 1'b1;
    tick();
    tick();
    chk("rst_word", {8'h00, tx_word}, 16'h0090);
    chk("rst_stop", {15'h0, tx_stop}, 16'h0);
    chk("rst_ready", {15'h0, smp_ready}, 16'h1);
    chk("rst_busy", {15'h0, cfg_busy}, 16'h0);
    chk("rst_ack", {15'h0, cfg_ack}, 16'h0);
    chk("rst_under", underrun_cnt, 16'h0);
    reset = 1'b0;
    tick();
    send(8'h90, 1'b0);
    send(8'h40, 1'b0);
    send(8'h00, 1'b0);
    chk("startup_under", underrun_cnt, 16'd1);
    foreach (sb_q[i]) ;
    for (int i = 1; i <= 4; i++) begin
      smp_data = 8'(i * 8'h11);
      smp_valid = 1'b1;
      tick();
    end
    chk("full_ready", {15'h0, smp_ready}, 16'h0);
    smp_data = 8'h55;
    tick();
    chk("full_hold", {15'h0, smp_ready}, 16'h0);
    send(8'h11, 1'b0);
    chk("pop_ready", {15'h0, smp_ready}, 16'h1);
    smp_valid = 1'b0;
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'h44, 1'b0);
    chk("stream_under", underrun_cnt, 16'd2);
    ack_seen = 0;
    cfg_ctrl = 8'h44;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    chk("cfg_busy_set", {15'h0, cfg_busy}, 16'h1);
    cfg_ctrl = 8'h00;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    send(8'h44, 1'b1);
    send(8'h90, 1'b0);
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    send(8'h44, 1'b0);
    chk("cfg_ack_pulse", {15'h0, cfg_ack}, 16'h1);
    chk("cfg_busy_clr", {15'h0, cfg_busy}, 16'h0);
    tick();
    chk("cfg_ack_low", {15'h0, cfg_ack}, 16'h0);
    chk("ack_count", 16'(ack_seen), 16'd1);
    send(8'h44, 1'b0);
    smp_data = 8'hA5;
    smp_valid = 1'b1;
    send(8'h44, 1'b0);
    smp_valid = 1'b0;
    chk("push_underrun", underrun_cnt, 16'd5);
    send(8'hA5, 1'b0);
    chk("head_after_push", underrun_cnt, 16'd5);
    exp_under = 16'd5;
    while (exp_under < 16'hFFFE) begin
      send(8'hA5, 1'b0);
      exp_under++;
    end
    chk("under_fffe", underrun_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) send(8'hA5, 1'b0);
    chk("under_sat", underrun_cnt, 16'hFFFF);
    smp_valid = 1'b1;
    smp_data = 8'h01;
    tick();
    smp_data = 8'h02;
    tick();
    smp_valid = 1'b0;
    cfg_ctrl = 8'h55;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    chk("pre_rst_busy", {15'h0, cfg_busy}, 16'h1);
    chk("pre_rst_stop", {15'h0, tx_stop}, 16'h1);
    ack_seen = 0;
    reset = 1'b1;
    #1;
    chk("midrst_word", {8'h00, tx_word}, 16'h0090);
    chk("midrst_ready", {15'h0, smp_ready}, 16'h1);
    chk("midrst_busy", {15'h0, cfg_busy}, 16'h0);
    chk("midrst_under", underrun_cnt, 16'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    send(8'h90, 1'b0);
    send(8'h40, 1'b0);
    send(8'h00, 1'b0);
    chk("post_rst_under", underrun_cnt, 16'd1);
    tick();
    chk("no_ack_after_rst", 16'(ack_seen), 16'd0);
    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
